// File: rtl/multi_cycle_processor.sv
// Multi-cycle core: every instruction walks FETCH/DECODE/EXECUTE/WRITEBACK (4 clocks).
// Adds BNZ, HALT (JMP +0), a program-load port, a registered debug read port and a retire counter.
//
// state     | meaning
// S_IDLE    | after reset; waits for Start, program loading allowed
// S_FETCH   | IR <= imem[PC]
// S_DECODE  | A/B operands latched from the register file or immediate
// S_EXECUTE | ALU result and next PC computed
// S_WRITEBACK | register write, PC update, retire count
// S_HALT    | stopped on JMP +0; waits for Start, program loading allowed
module multi_cycle_processor #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int PC_W   = 6,
  parameter int CNT_W  = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Prog_We,
  input  logic [PC_W-1:0]     Prog_Addr,
  input  logic [2*REG_AW+1:0] Prog_Data,
  input  logic [REG_AW-1:0]   Dbg_Addr,
  output logic [DATA_W-1:0]   Dbg_Data,
  output logic [PC_W-1:0]     PC,
  output logic                Busy,
  output logic                Halted,
  output logic [CNT_W-1:0]    Instr_Count
);

  localparam int INSTR_W = 2 + 2*REG_AW;
  localparam int NREG    = 2**REG_AW;
  localparam int IMEM_D  = 2**PC_W;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b10;
  localparam logic [1:0] OP_BNZ  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [INSTR_W-1:0]  imem [IMEM_D];
  logic [DATA_W-1:0]   regs [NREG];

  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   result;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     next_pc;
  logic [CNT_W-1:0]    count_q;

  logic [1:0]          opcode;
  logic [REG_AW-1:0]   ra;
  logic [REG_AW-1:0]   rb;
  logic [2*REG_AW-1:0] jmp_off;
  logic [DATA_W-1:0]   imm_data;
  logic [PC_W-1:0]     imm_pc;
  logic [PC_W-1:0]     off_pc;
  logic                halt_jmp;

  assign opcode   = ir[INSTR_W-1 -: 2];
  assign ra       = ir[2*REG_AW-1 -: REG_AW];
  assign rb       = ir[REG_AW-1:0];
  assign jmp_off  = ir[2*REG_AW-1:0];
  // Immediates and jump offsets are two's complement, sign-extended to their target width
  assign imm_data = DATA_W'($signed(rb));
  assign imm_pc   = PC_W'($signed(rb));
  assign off_pc   = PC_W'($signed(jmp_off));
  assign halt_jmp = (opcode == OP_JMP) && (jmp_off == '0);

  assign PC          = pc_q;
  assign Instr_Count = count_q;

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (Start) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = S_DECODE;
      S_DECODE:       state_nxt = S_EXECUTE;
      S_EXECUTE:      state_nxt = S_WRITEBACK;
      S_WRITEBACK:    state_nxt = halt_jmp ? S_HALT : S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Busy   = 1'b0;
    Halted = 1'b0;
    case (state)
      S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK: Busy = 1'b1;
      S_HALT:                                    Halted = 1'b1;
      default: ;
    endcase
  end

  // Program memory has no reset so a loaded program survives Reset
  always_ff @(posedge Clk) begin
    if (Prog_We && !Busy) imem[Prog_Addr] <= Prog_Data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q     <= '0;
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      next_pc  <= '0;
      count_q  <= '0;
      Dbg_Data <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      Dbg_Data <= regs[Dbg_Addr];
      case (state)
        S_IDLE, S_HALT: begin
          if (Start) begin
            pc_q    <= '0;
            count_q <= '0;
          end
        end
        S_FETCH: ir <= imem[pc_q];
        S_DECODE: begin
          op_a <= regs[ra];
          op_b <= (opcode == OP_ADD) ? regs[rb] : imm_data;
        end
        S_EXECUTE: begin
          result <= op_a + op_b;
          case (opcode)
            OP_JMP:  next_pc <= pc_q + off_pc;
            OP_BNZ:  next_pc <= (op_a != '0) ? pc_q + imm_pc : pc_q + PC_W'(1);
            default: next_pc <= pc_q + PC_W'(1);
          endcase
        end
        S_WRITEBACK: begin
          if (opcode == OP_ADD || opcode == OP_ADDI) regs[ra] <= result;
          pc_q <= next_pc;
          if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
